memory_dump_tx: RTL

//  Reads back the 32 x 16-bit instruction store and streams it out over UART TX, 8N1.
//  It is the transmit-side counterpart of the UART program loader.

---
 rtl/memory_dump_tx_pkg.sv | 18 +
 rtl/memory_dump_tx_uart.sv | 63 ++++++
 rtl/memory_dump_tx.sv | 110 +++++++++++
 3 files changed

// File: rtl/memory_dump_tx_pkg.sv
// Shared definitions for the instruction-store dump path: dump FSM
// encoding and the 8N1 UART frame constants.
package memory_dump_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SEND_HI,
        ST_SEND_LO,
        ST_NEXT
    } dump_state_t;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam int   DATA_BITS  = 8;
    localparam int   FRAME_BITS = DATA_BITS + 2;

endpackage

// File: rtl/memory_dump_tx_uart.sv
// Single-byte 8N1 UART transmitter; a whole frame is preloaded into a
// shift register so the serial line comes straight from a flop.
module uart_tx_byte
    import memory_dump_tx_pkg::*;
#(
    parameter int CLKS_PER_BAUD = 868
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 i_wr,
    input  logic [DATA_BITS-1:0] i_data,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_tx
);

    localparam int CNT_W = (CLKS_PER_BAUD > 1) ? $clog2(CLKS_PER_BAUD) : 1;
    localparam int IDX_W = $clog2(FRAME_BITS);

    logic [CNT_W-1:0]      baud_cnt;
    logic [IDX_W-1:0]      bit_idx;
    logic [FRAME_BITS-1:0] shreg;
    logic                  busy_r;
    logic                  baud_tick;
    logic                  last_bit;

    assign baud_tick = busy_r && (baud_cnt == CNT_W'(CLKS_PER_BAUD - 1));
    assign last_bit  = (bit_idx == IDX_W'(FRAME_BITS - 1));

    // Idle shift register is all ones so the line rests high, including during reset.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '1;
            busy_r   <= 1'b0;
        end else if (!busy_r) begin
            if (i_wr) begin
                busy_r   <= 1'b1;
                shreg    <= {STOP_BIT, i_data, START_BIT};
                baud_cnt <= '0;
                bit_idx  <= '0;
            end
        end else if (baud_tick) begin
            baud_cnt <= '0;
            if (last_bit) begin
                busy_r  <= 1'b0;
                bit_idx <= '0;
                shreg   <= '1;
            end else begin
                bit_idx <= bit_idx + IDX_W'(1);
                shreg   <= {STOP_BIT, shreg[FRAME_BITS-1:1]};
            end
        end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
        end
    end

    assign o_tx   = shreg[0];
    assign o_busy = busy_r;
    assign o_done = baud_tick && last_bit;

endmodule

// File: rtl/memory_dump_tx.sv
// Streams the whole instruction store out over UART, high byte of each
// word first, so a host can compare it against the image it loaded.
module memory_dump_tx
    import memory_dump_tx_pkg::*;
#(
    parameter int CLKS_PER_BAUD = 868,
    parameter int ADDR_W        = 5,
    parameter int WORD_W        = 16
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              start,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [WORD_W-1:0] rd_data,
    output logic              busy,
    output logic              dump_done,
    output logic              UART_RXD_OUT
);

    dump_state_t          state;
    dump_state_t          next_state;
    logic [WORD_W-1:0]    word_r;
    logic                 accept;
    logic                 last_addr;
    logic                 tx_wr;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_busy;
    logic                 tx_done;

    assign accept    = start && mem_ready && !busy;
    assign last_addr = (rd_addr == {ADDR_W{1'b1}});

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // The byte request is held until the transmitter takes it; leaving on
    // its done pulse guarantees each byte is issued exactly once.
    always_comb begin
        next_state = state;
        tx_wr      = 1'b0;
        tx_data    = word_r[DATA_BITS-1:0];
        case (state)
            ST_IDLE: begin
                if (accept) next_state = ST_FETCH;
            end
            ST_FETCH: begin
                next_state = ST_SEND_HI;
            end
            ST_SEND_HI: begin
                tx_wr   = !tx_busy;
                tx_data = word_r[WORD_W-1 -: DATA_BITS];
                if (tx_done) next_state = ST_SEND_LO;
            end
            ST_SEND_LO: begin
                tx_wr = !tx_busy;
                if (tx_done) next_state = ST_NEXT;
            end
            ST_NEXT: begin
                next_state = last_addr ? ST_IDLE : ST_FETCH;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // rd_addr stops at the last word so the host-visible address shows where the dump ended.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rd_addr   <= '0;
            word_r    <= '0;
            busy      <= 1'b0;
            dump_done <= 1'b0;
        end else begin
            if (accept) begin
                rd_addr   <= '0;
                busy      <= 1'b1;
                dump_done <= 1'b0;
            end
            if (state == ST_FETCH) begin
                word_r <= rd_data;
            end
            if (state == ST_NEXT) begin
                if (last_addr) begin
                    busy      <= 1'b0;
                    dump_done <= 1'b1;
                end else begin
                    rd_addr <= rd_addr + ADDR_W'(1);
                end
            end
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BAUD(CLKS_PER_BAUD)
    ) u_tx (
        .CLK   (CLK),
        .RST_N (RST_N),
        .i_wr  (tx_wr),
        .i_data(tx_data),
        .o_busy(tx_busy),
        .o_done(tx_done),
        .o_tx  (UART_RXD_OUT)
    );

endmodule
